mdu_ctrl: RTL
=============

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have ports `clk`, input, 1: the single clock, rising-edge.
REQ-002 SHALL have `reset`, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have `start`, input, 1: E-stage MDU operation valid this cycle.
REQ-004 SHALL have `md_op`, input, 3, with these codes:
- 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO.
- 6 and 7 are reserved and treated as no-op.
REQ-005 SHALL have `srcA`, input, 32: forwarded rs operand.
REQ-006 SHALL have `srcB`, input, 32: forwarded rt operand.
REQ-007 SHALL have `md_use_D`, input, 1: D-stage instruction is MULT/DIV/MTHI/MTLO/MFHI/MFLO.
REQ-008 SHALL have `busy`, output, 1: multi-cycle operation in progress.
REQ-009 SHALL have `stall_md`, output, 1: stall request to the hazard unit.
REQ-010 SHALL have `HI`, output, 32: architectural HI.
REQ-011 SHALL have `LO`, output, 32: architectural LO.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, with transitions:
- IDLE→RUN on `start` with a MULT/MULTU/DIV/DIVU op.
- RUN→IDLE when the down-counter reaches 1.
REQ-013 SHALL latch operands and op on accepted start, and load the counter:
- MULT_CYCLES=5 for MULT/MULTU.
- DIV_CYCLES=10 for DIV/DIVU.
REQ-014 SHALL assert `busy` from cycle t+1 through t+N for start in cycle t, and deassert it in t+N+1.
REQ-015 SHALL update HI/LO at the clock edge ending cycle t+N, so results are visible in t+N+1 together with `busy`=0.
REQ-016 SHALL compute MULT as signed 32x32→64 and MULTU as unsigned, with HI=product[63:32] and LO=product[31:0].
REQ-017 SHALL compute DIV/DIVU as LO=quotient and HI=remainder, with:
- Signed quotient truncated toward zero.
- Remainder taking the sign of the dividend.
REQ-018 SHALL handle division boundaries as follows:
- Signed 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0.
- Divisor 0 SHALL leave HI/LO unchanged but still occupy DIV_CYCLES.
REQ-019 SHALL write MTHI/MTLO srcA into HI/LO at the next edge, with no `busy` assertion.
REQ-020 SHALL ignore `start` while `busy`=1 (no state, counter or HI/LO change); this never occurs legally given REQ-021.
REQ-021 SHALL drive `stall_md` = `md_use_D` & (`start` | `busy`), combinationally.
REQ-022 SHALL ignore reserved `md_op` codes with `start`=1, with no state change.

Reset
REQ-023 SHALL, on `reset` asserted at any time (including mid-RUN):
- Abort the operation and force IDLE.
- Set the counter to 0, `busy`=0, HI=0, LO=0.
- Discard the pending result.
REQ-024 SHALL keep `stall_md` purely combinational, equal to `md_use_D` & `start` while reset is asserted.

Configuration
REQ-025 SHALL support the macro MDU_DIV_EN with this behaviour:
- Defined: DIV/DIVU SHALL be implemented per REQ-017/018.
- Undefined: DIV/DIVU SHALL be treated as no-op (no `busy`, HI/LO unchanged), and no divider logic SHALL be synthesized.

Structure
REQ-026 SHALL place the following in shared definitions package md_defs, used by the controller and this block:
- `md_op` encodings.
- MULT_CYCLES, DIV_CYCLES.
- FSM state encodings.
REQ-027 SHALL isolate the 64-bit result computation in one sub-module, mdu_core:
- Combinational product/quotient/remainder from the latched operands.
- Only the divider portion is guarded by MDU_DIV_EN.

Verification
REQ-028 SHALL verify MULT: srcA=0xFFFFFFFE, srcB=3, start at t → `busy` t+1..t+5; at t+6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-029 SHALL verify MULTU: srcA=0xFFFFFFFF, srcB=0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 SHALL verify DIV: srcA=0xFFFFFFF9 (-7), srcB=2 → `busy` 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. Additionally:
- 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by 0 → HI/LO unchanged.
REQ-031 SHALL verify stall and writes:
- `md_use_D`=1 during `start` and all busy cycles → `stall_md`=1 exactly those cycles, 0 at t+N+1.
- MTLO srcA=0x12345678 → LO=0x12345678 next cycle, `busy` stays 0.
REQ-032 SHALL verify reset mid-operation: reset asserted at t+3 of a DIV → `busy`=0, HI=LO=0 immediately; a new MULT accepted the cycle after release.
REQ-033 SHALL verify the build without MDU_DIV_EN: DIV start → `busy` never asserts, HI/LO unchanged.

Source files
------------

// File: rtl/md_defs.sv
// Shared MDU definitions: op encodings, latencies, FSM states and op decode helpers.
// Divide support is compiled in only when MDU_DIV_EN is defined.
package md_defs;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_RSV6  = 3'd6,
        OP_RSV7  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;
    localparam int CNT_W       = 4;

    // Occupancy of a multi-cycle op; 0 means the op never enters RUN.
    function automatic logic [CNT_W-1:0] op_cycles(input md_op_e op);
        logic [CNT_W-1:0] n;
        n = '0;
        case (op)
            OP_MULT, OP_MULTU: n = CNT_W'(MULT_CYCLES);
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU:   n = CNT_W'(DIV_CYCLES);
`endif
            default:           n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mdu_core.sv
// Combinational 64-bit MDU result from latched operands.
// The divider exists only when MDU_DIV_EN is defined.
module mdu_core
    import md_defs::*;
(
    input  md_op_e      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        wr
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Sign-extended 64x64 keeps the low 64 bits equal to the signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    assign neg_a = (op == OP_DIV) && a[31];
    assign neg_b = (op == OP_DIV) && b[31];
    assign mag_a = neg_a ? (~a + 32'd1) : a;
    assign mag_b = neg_b ? (~b + 32'd1) : b;
    assign uq    = (b == 32'd0) ? 32'd0 : mag_a / mag_b;
    assign ur    = (b == 32'd0) ? 32'd0 : mag_a % mag_b;
    // Truncating division: quotient sign from operand signs, remainder from dividend.
    assign quot  = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
    assign rem   = neg_a ? (~ur + 32'd1) : ur;
`endif

    always_comb begin
        hi = 32'd0;
        lo = 32'd0;
        wr = 1'b0;
        case (op)
            OP_MULT: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
                wr = 1'b1;
            end
            OP_MULTU: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
                wr = 1'b1;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
                hi = rem;
                lo = quot;
                wr = (b != 32'd0);
            end
`endif
            default: begin
                hi = 32'd0;
                lo = 32'd0;
                wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MDU controller: IDLE/RUN sequencing, HI/LO registers and the hazard stall request.
// DIV/DIVU are accepted only when MDU_DIV_EN is defined; otherwise they are no-ops.
module mdu_ctrl
    import md_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e        state_reg;
    md_state_e        state_next;
    logic [CNT_W-1:0] cnt_reg;
    md_op_e           op_reg;
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;

    md_op_e           op_in;
    logic [CNT_W-1:0] op_len;
    logic             idle_start;
    logic             accept;
    logic             finish;
    logic [31:0]      core_hi;
    logic [31:0]      core_lo;
    logic             core_wr;

    assign op_in      = md_op_e'(md_op);
    assign op_len     = op_cycles(op_in);
    assign idle_start = start && (state_reg == ST_IDLE);
    assign accept     = idle_start && (op_len != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == CNT_W'(1)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_reg == ST_RUN);
        finish = (state_reg == ST_RUN) && (cnt_reg == CNT_W'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
            op_reg  <= OP_MULT;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            hi_reg  <= 32'd0;
            lo_reg  <= 32'd0;
        end else begin
            if (accept) begin
                cnt_reg <= op_len;
                op_reg  <= op_in;
                a_reg   <= srcA;
                b_reg   <= srcB;
            end else if (state_reg == ST_RUN) begin
                cnt_reg <= cnt_reg - CNT_W'(1);
            end
            // Divide-by-zero reaches here with core_wr low, leaving HI/LO intact.
            if (finish && core_wr) begin
                hi_reg <= core_hi;
                lo_reg <= core_lo;
            end else if (idle_start && op_in == OP_MTHI) begin
                hi_reg <= srcA;
            end else if (idle_start && op_in == OP_MTLO) begin
                lo_reg <= srcA;
            end
        end
    end

    mdu_core u_core (
        .op (op_reg),
        .a  (a_reg),
        .b  (b_reg),
        .hi (core_hi),
        .lo (core_lo),
        .wr (core_wr)
    );

    assign stall_md = md_use_D & (start | busy);
    assign HI       = hi_reg;
    assign LO       = lo_reg;

endmodule
